mux_scan_ctrl: RTL



---
 rtl/mux_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Sweep controller for a 2**SEL_W:1 mux: steps the select through every index,
// holds each one for SETTLE+1 cycles and samples the mux output on the last of
// them. The samples are assembled into a parallel snapshot.
module mux_scan_ctrl #(
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic               y_in,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               done,
    output logic [2**SEL_W-1:0] data_out
);

    localparam int unsigned N     = 2 ** SEL_W;
    localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] SelLast = SEL_W'(N - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       cap_q, cap_d;
    logic [N-1:0]       data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: settle countdown, sampling, end-of-scan and abort handling.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                sel_d  = '0;
                if (start && !abort) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                    cap_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StWait: begin
                if (abort) begin
                    // Abort wins over a sample due on the same edge.
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    sel_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cap_d[sel_q] = y_in;
                    if (sel_q != SelLast) begin
                        sel_d = sel_q + SEL_W'(1);
                        cnt_d = CntLoad;
                    end else begin
                        // Last bit goes straight from y_in into the snapshot.
                        data_d = {y_in, cap_q[N-2:0]};
                        done_d = 1'b1;
                        sel_d  = '0;
                        if (cont) begin
                            cnt_d = CntLoad;
                            cap_d = '0;
                        end else begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                sel_d   = '0;
            end
        endcase
    end

    assign sel      = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;

endmodule
